// File: rtl/mux_arb.sv
// mux_arb: packet-level round-robin arbiter that drives the one-hot select of a 2:1 flit mux.
// Define MUX_ARB_STATS_EN to compile in per-input completed-packet counters and stats_clr.
module mux_arb #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic            ordy,
`ifdef MUX_ARB_STATS_EN
  input  logic            stats_clr,
  output logic [CNTW-1:0] pkt_cnt_0,
  output logic [CNTW-1:0] pkt_cnt_1,
`endif
  output logic [1:0]      sel,
  output logic            grant_0,
  output logic            grant_1,
  output logic            busy
);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;

  logic req_0, req_1;
  logic tail_0, tail_1;

  // prio names the input that wins when both present a HEAD in the same cycle
  function automatic state_t pick(input logic r0, input logic r1, input logic p);
    state_t nxt;
    nxt = IDLE;
    if (r0 && r1) begin
      nxt = p ? LOCK1 : LOCK0;
    end else if (r0) begin
      nxt = LOCK0;
    end else if (r1) begin
      nxt = LOCK1;
    end
    return nxt;
  endfunction

  always_comb begin
    req_0   = ivalid_0 & (itype_0 == TYPE_HEAD);
    req_1   = ivalid_1 & (itype_1 == TYPE_HEAD);
    grant_0 = ivalid_0 & sel_q[0] & ordy;
    grant_1 = ivalid_1 & sel_q[1] & ordy;
    tail_0  = grant_0 & (itype_0 == TYPE_TAIL);
    tail_1  = grant_1 & (itype_1 == TYPE_TAIL);
  end

  // Tail handover re-arbitrates in the same cycle with priority already flipped,
  // so a waiting head on the other input is locked with no idle bubble.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: state_d = pick(req_0, req_1, prio_q);
      LOCK0: begin
        if (tail_0) begin
          prio_d  = 1'b1;
          state_d = pick(req_0, req_1, 1'b1);
        end
      end
      LOCK1: begin
        if (tail_1) begin
          prio_d  = 1'b0;
          state_d = pick(req_0, req_1, 1'b0);
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d  = {state_d == LOCK1, state_d == LOCK0};
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;

`ifdef MUX_ARB_STATS_EN
  logic [CNTW-1:0] pkt_cnt_0_q, pkt_cnt_0_d;
  logic [CNTW-1:0] pkt_cnt_1_q, pkt_cnt_1_d;

  always_comb begin
    pkt_cnt_0_d = pkt_cnt_0_q;
    pkt_cnt_1_d = pkt_cnt_1_q;
    if (stats_clr) begin
      pkt_cnt_0_d = '0;
      pkt_cnt_1_d = '0;
    end else begin
      if (tail_0) pkt_cnt_0_d = pkt_cnt_0_q + CNTW'(1);
      if (tail_1) pkt_cnt_1_d = pkt_cnt_1_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      pkt_cnt_0_q <= '0;
      pkt_cnt_1_q <= '0;
    end else begin
      pkt_cnt_0_q <= pkt_cnt_0_d;
      pkt_cnt_1_q <= pkt_cnt_1_d;
    end
  end

  assign pkt_cnt_0 = pkt_cnt_0_q;
  assign pkt_cnt_1 = pkt_cnt_1_q;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Directed self-checking bench for mux_arb; stats checks run when MUX_ARB_STATS_EN is defined.
module tb_mux_arb;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       ivalid_0 = 1'b0, ivalid_1 = 1'b0;
  logic [1:0] itype_0 = T_NONE, itype_1 = T_NONE;
  logic       ordy = 1'b0;
  logic [1:0] sel;
  logic       grant_0, grant_1, busy;
`ifdef MUX_ARB_STATS_EN
  logic       stats_clr = 1'b0;
  logic [1:0] pkt_cnt_0, pkt_cnt_1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef MUX_ARB_STATS_EN
  mux_arb #(.CNTW(2)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy),
    .stats_clr(stats_clr), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1), .busy(busy)
  );
`else
  mux_arb dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1), .busy(busy)
  );
`endif

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ftype(input int idx, input int len);
    if (idx == 0) return T_HEAD;
    if (idx == len - 1) return T_TAIL;
    return T_DATA;
  endfunction

  task automatic test_reset();
    ivalid_0 = 1'b1; itype_0 = T_HEAD; ordy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b exp 00", sel); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_chk++;
    if (grant_0 !== 1'b0) begin n_fail++; $display("FAIL reset_grant0: got %b exp 0", grant_0); end
    rst_ = 1'b0;
    ivalid_0 = 1'b0; itype_0 = T_NONE;
    tick();
  endtask

  // Two 5-flit packets per input, heads presented together: order 0,1,0,1 with no bubbles.
  task automatic test_contention();
    int fc0, fc1;
    logic [1:0] exp_sel;
    fc0 = 0; fc1 = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      tick();
      ordy = 1'b1;
      ivalid_0 = (fc0 < 10); itype_0 = (fc0 < 10) ? ftype(fc0 % 5, 5) : T_NONE;
      ivalid_1 = (fc1 < 10); itype_1 = (fc1 < 10) ? ftype(fc1 % 5, 5) : T_NONE;
      #1;
      if (cyc == 0 || cyc == 21) exp_sel = 2'b00;
      else if (cyc <= 5 || (cyc >= 11 && cyc <= 15)) exp_sel = 2'b01;
      else exp_sel = 2'b10;
      n_chk++;
      if (sel !== exp_sel || grant_0 !== exp_sel[0] || grant_1 !== exp_sel[1]) begin
        n_fail++;
        $display("FAIL contention cyc%0d: sel=%b g0=%b g1=%b exp sel=%b", cyc, sel, grant_0, grant_1, exp_sel);
      end
      if (grant_0 === 1'b1) fc0++;
      if (grant_1 === 1'b1) fc1++;
    end
    n_chk++;
    if (fc0 != 10 || fc1 != 10) begin
      n_fail++; $display("FAIL contention_flits: got %0d/%0d exp 10/10", fc0, fc1);
    end
`ifdef MUX_ARB_STATS_EN
    n_chk++;
    if (pkt_cnt_0 !== 2'd2 || pkt_cnt_1 !== 2'd2) begin
      n_fail++; $display("FAIL contention_cnt: got %0d/%0d exp 2/2", pkt_cnt_0, pkt_cnt_1);
    end
`endif
    ivalid_0 = 1'b0; ivalid_1 = 1'b0;
  endtask

  task automatic test_single_packet();
    int ng;
    ng = 0;
    tick();
    ivalid_0 = 1'b1; itype_0 = T_HEAD; ordy = 1'b1;
    #1;
    n_chk++;
    if (sel !== 2'b00 || grant_0 !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: sel=%b g0=%b exp 00/0", sel, grant_0);
    end
    for (int i = 0; i < 22; i++) begin
      tick();
      itype_0 = ftype(i, 22);
      #1;
      n_chk++;
      if (sel !== 2'b01 || grant_0 !== 1'b1 || grant_1 !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_flit%0d: sel=%b g0=%b g1=%b busy=%b exp 01/1/0/1", i, sel, grant_0, grant_1, busy);
      end
      if (grant_0 === 1'b1) ng++;
    end
    tick();
    ivalid_0 = 1'b0; itype_0 = T_NONE;
    #1;
    n_chk++;
    if (sel !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: sel=%b busy=%b exp 00/0", sel, busy);
    end
    n_chk++;
    if (ng != 22) begin n_fail++; $display("FAIL single_grants: got %0d exp 22", ng); end
`ifdef MUX_ARB_STATS_EN
    n_chk++;
    if (pkt_cnt_0 !== 2'd3) begin n_fail++; $display("FAIL single_cnt: got %0d exp 3", pkt_cnt_0); end
`endif
  endtask

  task automatic test_backpressure();
    int fc;
    logic [1:0] exp_sel;
    logic exp_g;
    fc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      ordy = !(cyc >= 3 && cyc <= 5);
      ivalid_0 = (fc < 5); itype_0 = (fc < 5) ? ftype(fc, 5) : T_NONE;
      #1;
      exp_sel = (cyc == 0 || cyc == 9) ? 2'b00 : 2'b01;
      exp_g   = (exp_sel == 2'b01) && !(cyc >= 3 && cyc <= 5);
      n_chk++;
      if (sel !== exp_sel || grant_0 !== exp_g || grant_1 !== 1'b0 || busy !== exp_sel[0]) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: sel=%b g0=%b busy=%b exp sel=%b g0=%b", cyc, sel, grant_0, busy, exp_sel, exp_g);
      end
      if (grant_0 === 1'b1) fc++;
    end
    n_chk++;
    if (fc != 5) begin n_fail++; $display("FAIL backpressure_flits: got %0d exp 5", fc); end
    ordy = 1'b1;
  endtask

  task automatic test_protocol();
    logic [1:0] types [4];
    types = '{T_DATA, T_TAIL, T_NONE, T_DATA};
    for (int i = 0; i < 5; i++) begin
      tick();
      ivalid_0 = 1'b0;
      ivalid_1 = (i < 4);
      itype_1  = (i < 4) ? types[i] : T_NONE;
      #1;
      n_chk++;
      if (sel !== 2'b00 || busy !== 1'b0 || grant_1 !== 1'b0) begin
        n_fail++; $display("FAIL protocol cyc%0d: sel=%b busy=%b g1=%b exp 00/0/0", i, sel, busy, grant_1);
      end
    end
  endtask

  // prio is 1 entering this task; a reset must return it to 0.
  task automatic test_reset_mid_packet();
    tick();
    ivalid_1 = 1'b1; itype_1 = T_HEAD; ordy = 1'b1;
    tick();
    #1;
    n_chk++;
    if (sel !== 2'b10 || grant_1 !== 1'b1) begin
      n_fail++; $display("FAIL lock1_head: sel=%b g1=%b exp 10/1", sel, grant_1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ivalid_1 = 1'b0; itype_1 = T_NONE;
      #1;
      n_chk++;
      if (sel !== 2'b10 || busy !== 1'b1 || grant_1 !== 1'b0) begin
        n_fail++; $display("FAIL lock_hold cyc%0d: sel=%b busy=%b g1=%b exp 10/1/0", i, sel, busy, grant_1);
      end
    end
    tick();
    ivalid_1 = 1'b1; itype_1 = T_DATA;
    #1;
    rst_ = 1'b1;
    #1;
    n_chk++;
    if (sel !== 2'b00 || busy !== 1'b0 || grant_1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: sel=%b busy=%b g1=%b exp 00/0/0", sel, busy, grant_1);
    end
    tick();
    rst_ = 1'b0;
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    ivalid_1 = 1'b1; itype_1 = T_HEAD;
    tick();
    #1;
    n_chk++;
    if (sel !== 2'b01) begin n_fail++; $display("FAIL reset_prio: sel=%b exp 01", sel); end
    ivalid_0 = 1'b0; ivalid_1 = 1'b0;
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
  endtask

`ifdef MUX_ARB_STATS_EN
  task automatic test_stats();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ivalid_0 = 1'b1; itype_0 = T_HEAD; ordy = 1'b1;
      tick();
      tick();
      itype_0 = T_TAIL;
      tick();
      ivalid_0 = 1'b0; itype_0 = T_NONE;
      #1;
      n_chk++;
      if (pkt_cnt_0 !== exp_c[k]) begin
        n_fail++; $display("FAIL stats_wrap pkt%0d: got %0d exp %0d", k, pkt_cnt_0, exp_c[k]);
      end
      tick();
    end
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    tick();
    tick();
    itype_0 = T_TAIL; stats_clr = 1'b1;
    #1;
    n_chk++;
    if (grant_0 !== 1'b1) begin n_fail++; $display("FAIL stats_tail_grant: got %b exp 1", grant_0); end
    tick();
    stats_clr = 1'b0; ivalid_0 = 1'b0; itype_0 = T_NONE;
    #1;
    n_chk++;
    if (pkt_cnt_0 !== 2'd0 || pkt_cnt_1 !== 2'd0) begin
      n_fail++; $display("FAIL stats_clr: got %0d/%0d exp 0/0", pkt_cnt_0, pkt_cnt_1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_packet();
    test_backpressure();
    test_protocol();
    test_reset_mid_packet();
`ifdef MUX_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
